// File: rtl/ahb_sram_responder.sv
// ahb_sram_responder: zero-wait-state AHB-Lite slave in front of a single-port
// synchronous SRAM (1-cycle read latency, byte write enables).
// Writes land in a one-entry buffer that drains into the SRAM on a later free
// cycle. Buffered bytes are forwarded into read data so reads never see stale data.
// Optional feature macro: AHB_SRAM_ERR_EN. When it is defined, out-of-range,
// oversize and misaligned transfers get a two-cycle ERROR response.
module ahb_sram_responder #(
  parameter int AW    = 15,
  parameter int WORDS = (1 << AW)
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic          HSEL,
  input  logic [31:0]   HADDR,
  input  logic [1:0]    HTRANS,
  input  logic          HWRITE,
  input  logic [2:0]    HSIZE,
  input  logic [31:0]   HWDATA,
  input  logic          HREADY,
  output logic          HREADYOUT,
  output logic          HRESP,
  output logic [31:0]   HRDATA,
  output logic          SRAMCS,
  output logic [3:0]    SRAMWEN,
  output logic [AW-1:0] SRAMADDR,
  output logic [31:0]   SRAMWDATA,
  input  logic [31:0]   SRAMRDATA
);

`ifdef AHB_SRAM_ERR_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_t;
`else
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DATA = 1'b1
  } state_t;
`endif

  state_t state;
  state_t state_next;

  logic [AW-1:0] word_idx;
  logic [3:0]    lanes;
  logic          stall;
  logic          accept;
  logic          req_err;
  logic          ok_accept;
  logic          rd_accept;
  logic          wr_accept;
  logic          wr_dphase;
  logic          rd_dphase;
  logic          drain_buf;
  logic          drain_bypass;
  logic          fwd_hit;

  // Data-phase bookkeeping
  logic          dp_write;
  logic [AW-1:0] rd_addr;

  // One-entry write buffer: header loads on the write accept, data on its data phase
  logic          buf_valid;
  logic [AW-1:0] buf_addr;
  logic [3:0]    buf_strb;
  logic [31:0]   buf_data;

  // Upper address bits are ignored, so the word index wraps modulo 2^AW
  assign word_idx = HADDR[AW+1:2];

  // Byte-lane strobes for the addressed transfer; oversize acts as word and misaligned aligns down
  always_comb begin
    lanes = 4'b1111;
    case (HSIZE)
      3'd0:    lanes = 4'b0001 << HADDR[1:0];
      3'd1:    lanes = HADDR[1] ? 4'b1100 : 4'b0011;
      default: lanes = 4'b1111;
    endcase
  end

`ifdef AHB_SRAM_ERR_EN
  // Flag transfers that must receive an ERROR response instead of touching memory
  always_comb begin
    req_err = 1'b0;
    if (32'(word_idx) >= 32'(WORDS))                 req_err = 1'b1;
    if (HSIZE > 3'd2)                                 req_err = 1'b1;
    if ((HSIZE == 3'd1) && HADDR[0])                  req_err = 1'b1;
    if ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00))     req_err = 1'b1;
  end
  assign stall = (state == ST_ERR1);
`else
  assign req_err = 1'b0;
  assign stall   = 1'b0;
`endif

  assign accept       = HSEL & HREADY & HTRANS[1] & ~stall;
  assign ok_accept    = accept & ~req_err;
  assign rd_accept    = ok_accept & ~HWRITE;
  assign wr_accept    = ok_accept & HWRITE;
  assign wr_dphase    = (state == ST_DATA) & dp_write;
  assign rd_dphase    = (state == ST_DATA) & ~dp_write;
  // A full buffer drains on any cycle that the SRAM is not needed for a read
  assign drain_buf    = buf_valid & ~rd_accept;
  // Back-to-back writes: the older entry's data is still on HWDATA, so write it straight through
  assign drain_bypass = wr_dphase & wr_accept;
  assign fwd_hit      = buf_valid & (buf_addr == rd_addr);

  // State register
  always_ff @(posedge HCLK) begin
    if (HRESET) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state and bus response: always ready except the first ERROR cycle
  always_comb begin
    state_next = ST_IDLE;
    HREADYOUT  = 1'b1;
    HRESP      = 1'b0;
    if (ok_accept) state_next = ST_DATA;
`ifdef AHB_SRAM_ERR_EN
    if (accept && req_err) state_next = ST_ERR1;
    if (state == ST_ERR1) begin
      HREADYOUT  = 1'b0;
      HRESP      = 1'b1;
      state_next = ST_ERR2;
    end
    if (state == ST_ERR2) HRESP = 1'b1;
`endif
  end

  // Remember the kind and address of the transfer that owns the next data phase
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dp_write <= 1'b0;
      rd_addr  <= '0;
    end else if (ok_accept) begin
      dp_write <= HWRITE;
      rd_addr  <= word_idx;
    end
  end

  // Write buffer: load header on accept, capture data in the data phase, clear on drain
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      buf_valid <= 1'b0;
      buf_addr  <= '0;
      buf_strb  <= '0;
      buf_data  <= '0;
    end else if (wr_accept) begin
      buf_valid <= 1'b0;
      buf_addr  <= word_idx;
      buf_strb  <= lanes;
    end else if (wr_dphase) begin
      buf_valid <= 1'b1;
      buf_data  <= HWDATA;
    end else if (drain_buf) begin
      buf_valid <= 1'b0;
    end
  end

  // SRAM port arbitration: read accepts win, otherwise a pending buffer entry drains
  always_comb begin
    SRAMCS    = 1'b0;
    SRAMWEN   = 4'b0000;
    SRAMADDR  = word_idx;
    SRAMWDATA = buf_data;
    if (!HRESET) begin
      if (rd_accept) begin
        SRAMCS   = 1'b1;
        SRAMADDR = word_idx;
      end else if (drain_buf) begin
        SRAMCS    = 1'b1;
        SRAMWEN   = buf_strb;
        SRAMADDR  = buf_addr;
        SRAMWDATA = buf_data;
      end else if (drain_bypass) begin
        SRAMCS    = 1'b1;
        SRAMWEN   = buf_strb;
        SRAMADDR  = buf_addr;
        SRAMWDATA = HWDATA;
      end
    end
  end

  // Read data: SRAM word with any still-buffered bytes for the same word merged in
  always_comb begin
    HRDATA = '0;
    if (rd_dphase) begin
      for (int i = 0; i < 4; i++) begin
        HRDATA[8*i +: 8] = (fwd_hit && buf_strb[i]) ? buf_data[8*i +: 8]
                                                     : SRAMRDATA[8*i +: 8];
      end
    end
  end

  logic unused_bits;
  assign unused_bits = &{1'b0, HADDR[31:AW+2], HTRANS[0], (WORDS > 0)};

endmodule

// File: tb/tb_ahb_sram_responder.sv
// tb_ahb_sram_responder: directed table of bus cycles with hand-computed SRAM
// strobes and read data, plus sequences for reset-in-data-phase and ERROR responses.
module tb_ahb_sram_responder;
  localparam int AW = 15;

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic          HSEL;
  logic [31:0]   HADDR;
  logic [1:0]    HTRANS;
  logic          HWRITE;
  logic [2:0]    HSIZE;
  logic [31:0]   HWDATA;
  logic          HREADY;
  logic          HREADYOUT;
  logic          HRESP;
  logic [31:0]   HRDATA;
  logic          SRAMCS;
  logic [3:0]    SRAMWEN;
  logic [AW-1:0] SRAMADDR;
  logic [31:0]   SRAMWDATA;
  logic [31:0]   SRAMRDATA;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:(1<<AW)-1];

  typedef struct {
    logic        hsel;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        e_cs;
    logic [3:0]  e_wen;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        chk_rd;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs[$];

  ahb_sram_responder #(.AW(AW)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA), .SRAMCS(SRAMCS),
    .SRAMWEN(SRAMWEN), .SRAMADDR(SRAMADDR), .SRAMWDATA(SRAMWDATA),
    .SRAMRDATA(SRAMRDATA)
  );

  // Free-running bus clock
  always #5 HCLK = ~HCLK;

  // Behavioural SRAM macro: one-cycle read latency, byte write enables
  always @(posedge HCLK) begin
    if (SRAMCS) begin
      if (SRAMWEN == 4'b0000) SRAMRDATA <= mem[SRAMADDR];
      else begin
        for (int i = 0; i < 4; i++)
          if (SRAMWEN[i]) mem[SRAMADDR][8*i +: 8] <= SRAMWDATA[8*i +: 8];
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic hsel, input logic [1:0] trans, input logic write,
                         input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic e_cs, input logic [3:0] e_wen, input logic [31:0] e_addr,
                         input logic [31:0] e_wdata, input logic chk_rd, input logic [31:0] e_rdata);
    vec_t v;
    v.hsel = hsel; v.trans = trans; v.write = write; v.size = size; v.addr = addr;
    v.wdata = wdata; v.e_cs = e_cs; v.e_wen = e_wen; v.e_addr = e_addr;
    v.e_wdata = e_wdata; v.chk_rd = chk_rd; v.e_rdata = e_rdata;
    vecs.push_back(v);
  endtask

  task automatic apply_stimulus(input vec_t v);
    HSEL   = v.hsel;
    HTRANS = v.trans;
    HWRITE = v.write;
    HSIZE  = v.size;
    HADDR  = v.addr;
    HWDATA = v.wdata;
    HREADY = 1'b1;
  endtask

  task automatic check_vector(input int n, input vec_t v);
    check_output($sformatf("v%0d hreadyout", n), 32'(HREADYOUT), 32'd1);
    check_output($sformatf("v%0d hresp", n), 32'(HRESP), 32'd0);
    check_output($sformatf("v%0d sramcs", n), 32'(SRAMCS), 32'(v.e_cs));
    if (v.e_cs) begin
      check_output($sformatf("v%0d sramwen", n), 32'(SRAMWEN), 32'(v.e_wen));
      check_output($sformatf("v%0d sramaddr", n), 32'(SRAMADDR), v.e_addr);
      if (v.e_wen != 4'b0000)
        check_output($sformatf("v%0d sramwdata", n), SRAMWDATA, v.e_wdata);
    end
    if (v.chk_rd) check_output($sformatf("v%0d hrdata", n), HRDATA, v.e_rdata);
  endtask

  task automatic idle_bus();
    HSEL = 1'b1; HTRANS = 2'b00; HWRITE = 1'b0; HSIZE = 3'd2;
    HADDR = '0; HWDATA = '0; HREADY = 1'b1;
  endtask

  // Directed test sequence
  initial begin
    for (int i = 0; i < (1<<AW); i++) mem[i] <= '0;
    mem[4]  <= 32'h1122_3344;
    mem[8]  <= 32'h5566_7788;
    mem[17] <= 32'h1717_1717;
    mem[18] <= 32'hCCCC_CCCC;
    mem[20] <= 32'h2020_2020;

    // Columns: hsel trans write size addr wdata | cs wen addr wdata chk_rd rdata
    // Byte write 0xA5 @0x13, then read 0x10: forwarded byte over old word
    add_vec(1, 2, 1, 0, 32'h13, 0,            0, 4'b0000, 0, 0, 0, 0);
    add_vec(1, 2, 0, 2, 32'h10, 32'hA500_0000, 1, 4'b0000, 4, 0, 0, 0);
    add_vec(1, 0, 0, 0, 0, 0,                 1, 4'b1000, 4, 32'hA500_0000, 1, 32'hA522_3344);
    add_vec(1, 0, 0, 0, 0, 0,                 0, 4'b0000, 0, 0, 0, 0);
    // Word write 0x10 <= DEADBEEF, idle, drain, read back
    add_vec(1, 2, 1, 2, 32'h10, 0,            0, 4'b0000, 0, 0, 0, 0);
    add_vec(1, 0, 0, 0, 0, 32'hDEAD_BEEF,     0, 4'b0000, 0, 0, 0, 0);
    add_vec(1, 0, 0, 0, 0, 0,                 1, 4'b1111, 4, 32'hDEAD_BEEF, 0, 0);
    add_vec(1, 2, 0, 2, 32'h10, 0,            1, 4'b0000, 4, 0, 0, 0);
    add_vec(1, 0, 0, 0, 0, 0,                 0, 4'b0000, 0, 0, 1, 32'hDEAD_BEEF);
    // Half write 0xBEEF @0x22
    add_vec(1, 2, 1, 1, 32'h22, 0,            0, 4'b0000, 0, 0, 0, 0);
    add_vec(1, 0, 0, 0, 0, 32'hBEEF_0000,     0, 4'b0000, 0, 0, 0, 0);
    add_vec(1, 0, 0, 0, 0, 0,                 1, 4'b1100, 8, 32'hBEEF_0000, 0, 0);
    add_vec(1, 2, 0, 2, 32'h20, 0,            1, 4'b0000, 8, 0, 0, 0);
    add_vec(1, 0, 0, 0, 0, 0,                 0, 4'b0000, 0, 0, 1, 32'hBEEF_7788);
    // Write A(0x40), write B(0x44), read C(0x48), read B, read A back-to-back
    add_vec(1, 2, 1, 2, 32'h40, 0,            0, 4'b0000, 0, 0, 0, 0);
    add_vec(1, 2, 1, 2, 32'h44, 32'h0A0A_0A0A, 1, 4'b1111, 16, 32'h0A0A_0A0A, 0, 0);
    add_vec(1, 2, 0, 2, 32'h48, 32'h0B0B_0B0B, 1, 4'b0000, 18, 0, 0, 0);
    add_vec(1, 2, 0, 2, 32'h44, 0,            1, 4'b0000, 17, 0, 1, 32'hCCCC_CCCC);
    add_vec(1, 2, 0, 2, 32'h40, 0,            1, 4'b0000, 16, 0, 1, 32'h0B0B_0B0B);
    add_vec(1, 0, 0, 0, 0, 0,                 1, 4'b1111, 17, 32'h0B0B_0B0B, 1, 32'h0A0A_0A0A);
    add_vec(1, 2, 0, 2, 32'h44, 0,            1, 4'b0000, 17, 0, 0, 0);
    add_vec(1, 0, 0, 0, 0, 0,                 0, 4'b0000, 0, 0, 1, 32'h0B0B_0B0B);
    // Byte write 0x5A @0x41 immediately followed by a read of the same word
    add_vec(1, 2, 1, 0, 32'h41, 0,            0, 4'b0000, 0, 0, 0, 0);
    add_vec(1, 2, 0, 2, 32'h40, 32'h0000_5A00, 1, 4'b0000, 16, 0, 0, 0);
    add_vec(1, 0, 0, 0, 0, 0,                 1, 4'b0010, 16, 32'h0000_5A00, 1, 32'h0A0A_5A0A);
    // Not selected, then BUSY: no SRAM activity
    add_vec(0, 2, 0, 2, 32'h10, 0,            0, 4'b0000, 0, 0, 0, 0);
    add_vec(1, 1, 0, 2, 32'h10, 0,            0, 4'b0000, 0, 0, 0, 0);
`ifndef AHB_SRAM_ERR_EN
    // Upper bits wrap and misaligned word aligns down: 0x0002_0012 -> word 4
    add_vec(1, 2, 0, 2, 32'h0002_0012, 0,     1, 4'b0000, 4, 0, 0, 0);
    add_vec(1, 0, 0, 0, 0, 0,                 0, 4'b0000, 0, 0, 1, 32'hDEAD_BEEF);
    // Oversize write behaves as a word write at the aligned address
    add_vec(1, 2, 1, 3, 32'h49, 0,            0, 4'b0000, 0, 0, 0, 0);
    add_vec(1, 0, 0, 0, 0, 32'h1234_5678,     0, 4'b0000, 0, 0, 0, 0);
    add_vec(1, 0, 0, 0, 0, 0,                 1, 4'b1111, 18, 32'h1234_5678, 0, 0);
    add_vec(1, 2, 0, 2, 32'h48, 0,            1, 4'b0000, 18, 0, 0, 0);
    add_vec(1, 0, 0, 0, 0, 0,                 0, 4'b0000, 0, 0, 1, 32'h1234_5678);
`endif

    // Reset values
    idle_bus();
    HRESET = 1'b1;
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    check_output("reset hreadyout", 32'(HREADYOUT), 32'd1);
    check_output("reset hresp", 32'(HRESP), 32'd0);
    check_output("reset hrdata", HRDATA, 32'd0);
    check_output("reset sramcs", 32'(SRAMCS), 32'd0);
    check_output("reset sramwen", 32'(SRAMWEN), 32'd0);
    @(posedge HCLK);
    #1 HRESET = 1'b0;

    for (int n = 0; n < vecs.size(); n++) begin
      apply_stimulus(vecs[n]);
      @(negedge HCLK);
      check_vector(n, vecs[n]);
      @(posedge HCLK);
      #1;
    end

    // Reset during a write data phase discards the pending write
    idle_bus();
    HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h50;
    @(posedge HCLK); #1;
    idle_bus();
    HWDATA = 32'hFFFF_FFFF;
    HRESET = 1'b1;
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    HWDATA = '0;
    @(negedge HCLK);
    check_output("rst-dphase sramcs", 32'(SRAMCS), 32'd0);
    check_output("rst-dphase hreadyout", 32'(HREADYOUT), 32'd1);
    check_output("rst-dphase hrdata", HRDATA, 32'd0);
    @(posedge HCLK); #1;
    @(negedge HCLK);
    check_output("rst-dphase no drain", 32'(SRAMCS), 32'd0);
    @(posedge HCLK); #1;
    HTRANS = 2'b10; HADDR = 32'h50;
    @(negedge HCLK);
    check_output("rst-dphase read cs", 32'(SRAMCS), 32'd1);
    check_output("rst-dphase read addr", 32'(SRAMADDR), 32'd20);
    @(posedge HCLK); #1;
    idle_bus();
    @(negedge HCLK);
    check_output("rst-dphase old data", HRDATA, 32'h2020_2020);

`ifdef AHB_SRAM_ERR_EN
    // Misaligned word read gets a two-cycle ERROR and no SRAM access
    @(posedge HCLK); #1;
    HTRANS = 2'b10; HADDR = 32'h02; HSIZE = 3'd2;
    @(negedge HCLK);
    check_output("err addr-phase cs", 32'(SRAMCS), 32'd0);
    @(posedge HCLK); #1;
    idle_bus();
    HREADY = 1'b0;
    @(negedge HCLK);
    check_output("err1 hreadyout", 32'(HREADYOUT), 32'd0);
    check_output("err1 hresp", 32'(HRESP), 32'd1);
    check_output("err1 cs", 32'(SRAMCS), 32'd0);
    @(posedge HCLK); #1;
    HREADY = 1'b1;
    @(negedge HCLK);
    check_output("err2 hreadyout", 32'(HREADYOUT), 32'd1);
    check_output("err2 hresp", 32'(HRESP), 32'd1);
    check_output("err2 cs", 32'(SRAMCS), 32'd0);
    @(posedge HCLK); #1;
    @(negedge HCLK);
    check_output("err done hresp", 32'(HRESP), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
